data_bus_receive_ml: RTL and testbench

Parametrised multi-lane successor of the USB4 logical-layer lane receive block. It accepts byte-aligned symbols from NUM_LANES lanes and detects Gen3/Gen4 ordered sets selected by d_sel. Each lane requires MATCH_REPEAT consecutive matching sets before it reports, with one pulse per lock. In data mode it forwards all lanes as one word to the transport layer. It sits between the lane adapters and the LTSSM / transport layer.

---
 rtl/data_bus_receive_ml_if.sv | 26 ++
 rtl/data_bus_receive_ml.sv | 142 ++++++++++++++
 tb/tb_data_bus_receive_ml.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_receive_ml_if.sv
// Lane-adapter side bus of the multi-lane receive block: lane symbols and controls in,
// per-lane ordered-set status and the forwarded transport word out.
interface data_bus_receive_ml_if #(
    parameter int NUM_LANES = 2,
    parameter int BYTE_W    = 8
);
    logic                          lane_rx_on;
    logic                          lane_rx_valid;
    logic                          data_os;
    logic [3:0]                    d_sel;
    logic [NUM_LANES*BYTE_W-1:0]   lane_rx;
    logic [NUM_LANES*4-1:0]        os_in;
    logic [NUM_LANES-1:0]          os_lock;
    logic [NUM_LANES*BYTE_W-1:0]   transport_layer_data_out;
    logic                          transport_layer_data_valid;

    modport master (
        output lane_rx_on, lane_rx_valid, data_os, d_sel, lane_rx,
        input  os_in, os_lock, transport_layer_data_out, transport_layer_data_valid
    );

    modport slave (
        input  lane_rx_on, lane_rx_valid, data_os, d_sel, lane_rx,
        output os_in, os_lock, transport_layer_data_out, transport_layer_data_valid
    );
endinterface

// File: rtl/data_bus_receive_ml.sv
// Multi-lane receive: per-lane Gen3/Gen4 ordered-set detection with repeat gating and lock,
// plus data-mode forwarding. Optional LANE_REVERSAL_EN adds lane_reverse (logical lane remap).
module data_bus_receive_ml #(
    parameter int NUM_LANES    = 2,
    parameter int BYTE_W       = 8,
    parameter int OS_BYTES     = 8,
    parameter int MATCH_REPEAT = 2
) (
    input  logic clk,
    input  logic rst,
`ifdef LANE_REVERSAL_EN
    input  logic lane_reverse,
`endif
    data_bus_receive_ml_if.slave bus
);
    localparam int SH_W  = OS_BYTES * BYTE_W;
    localparam int CNT_W = (OS_BYTES > 1) ? $clog2(OS_BYTES) : 1;
    localparam int CMP_W = (SH_W < 64) ? SH_W : 64;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS_BYTES - 1);
    localparam logic [3:0]       REP_TGT  = 4'(MATCH_REPEAT);

    logic                        rev;
    logic                        rev_reg;
    logic [3:0]                  dsel_reg;
    logic [CNT_W-1:0]            cnt_reg;
    logic [NUM_LANES*BYTE_W-1:0] data_out_reg;
    logic                        data_valid_reg;
    logic [NUM_LANES*BYTE_W-1:0] rx_log;
    logic                        boundary;
    logic                        os_mode;
    logic                        clr;

`ifdef LANE_REVERSAL_EN
    assign rev = lane_reverse;
`else
    assign rev = 1'b0;
`endif

    assign boundary = bus.lane_rx_valid && (cnt_reg == CNT_LAST);
    assign os_mode  = (bus.d_sel >= 4'd2) && (bus.d_sel <= 4'd7);
    // Any selector or lane-map change, or a non-OS selector, drops every lane's progress.
    assign clr      = (bus.d_sel != dsel_reg) || (rev != rev_reg) || !os_mode;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg        <= '0;
            dsel_reg       <= 4'h0;
            rev_reg        <= 1'b0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            dsel_reg <= bus.d_sel;
            rev_reg  <= rev;
            if (!bus.lane_rx_on) begin
                cnt_reg        <= '0;
                data_out_reg   <= '0;
                data_valid_reg <= 1'b0;
            end else begin
                if (bus.lane_rx_valid)
                    cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
                data_valid_reg <= 1'b0;
                if (bus.d_sel == 4'd8 && bus.data_os && bus.lane_rx_valid) begin
                    data_out_reg   <= rx_log;
                    data_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.transport_layer_data_out   = data_out_reg;
    assign bus.transport_layer_data_valid = data_valid_reg;

    // Everything past the input remap works in logical lane order.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        localparam logic [7:0] LANE_N = 8'(gi);

        logic [SH_W-1:0] sh_reg;
        logic [SH_W-1:0] sh_shift;
        logic [63:0]     win;
        logic            match;
        logic [3:0]      rep_reg;
        logic [3:0]      rep_inc;
        logic            lock_reg;
        logic [3:0]      os_reg;

        assign rx_log[gi*BYTE_W +: BYTE_W] = rev ? bus.lane_rx[(NUM_LANES-1-gi)*BYTE_W +: BYTE_W]
                                                 : bus.lane_rx[gi*BYTE_W +: BYTE_W];

        assign sh_shift = (sh_reg << BYTE_W) | SH_W'(rx_log[gi*BYTE_W +: BYTE_W]);
        assign win      = 64'(sh_shift[CMP_W-1:0]);
        assign rep_inc  = (rep_reg == 4'hF) ? 4'hF : rep_reg + 4'd1;

        always_comb begin
            match = 1'b0;
            case (bus.d_sel)
                4'd2:    match = (win == {8'h01, LANE_N, 48'h0000_0400_98F2});
                4'd3:    match = (win == {8'h01, LANE_N, 48'h0000_0400_64F2});
                4'd4:    match = (win[23:0] == 24'h7E02D0);
                4'd5:    match = (win[31:0] == 32'h7E04B0F0);
                4'd6:    match = (win[31:0] == 32'h7E0690F0);
                4'd7:    match = (win[31:0] == 32'h7E0F0F00);
                default: match = 1'b0;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sh_reg   <= '0;
                rep_reg  <= 4'd0;
                lock_reg <= 1'b0;
                os_reg   <= 4'h9;
            end else if (!bus.lane_rx_on) begin
                sh_reg   <= '0;
                rep_reg  <= 4'd0;
                lock_reg <= 1'b0;
                os_reg   <= 4'h9;
            end else begin
                os_reg <= 4'h9;
                if (bus.lane_rx_valid)
                    sh_reg <= sh_shift;
                if (clr) begin
                    rep_reg  <= 4'd0;
                    lock_reg <= 1'b0;
                end else if (boundary) begin
                    if (match) begin
                        rep_reg <= rep_inc;
                        if (rep_inc >= REP_TGT && !lock_reg) begin
                            os_reg   <= bus.d_sel;
                            lock_reg <= 1'b1;
                        end
                    end else begin
                        rep_reg  <= 4'd0;
                        lock_reg <= 1'b0;
                    end
                end
            end
        end

        assign bus.os_in[gi*4 +: 4] = os_reg;
        assign bus.os_lock[gi]      = lock_reg;
    end
endmodule

// File: tb/tb_data_bus_receive_ml.sv
// Scoreboard bench for data_bus_receive_ml: stimulus queues expected output events with their
// cycle, a monitor pops and compares whenever os_in leaves idle or data_valid strobes.
module tb_data_bus_receive_ml;
    localparam int NL = 2;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
`ifdef LANE_REVERSAL_EN
    logic lane_reverse = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [7:0]  os;
        logic        dv;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    data_bus_receive_ml_if #(.NUM_LANES(NL), .BYTE_W(BW)) bus ();

    data_bus_receive_ml #(.NUM_LANES(NL), .BYTE_W(BW), .OS_BYTES(8), .MATCH_REPEAT(2)) dut (
        .clk(clk),
        .rst(rst),
`ifdef LANE_REVERSAL_EN
        .lane_reverse(lane_reverse),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else
            $display("ok   %s: %h", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b0, input logic [7:0] b1);
        bus.lane_rx_valid = 1'b1;
        bus.lane_rx       = {b1, b0};
        tick();
        bus.lane_rx_valid = 1'b0;
    endtask

    // Sends one 8-byte set per lane MSB byte first; exp_os other than 8'h99 is the pulse due
    // right after the final byte.
    task automatic send_set(input logic [63:0] s0, input logic [63:0] s1, input logic [7:0] exp_os);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && exp_os !== 8'h99)
                exp_q.push_back('{cyc + 1, exp_os, 1'b0, 16'h0000});
            send_byte(s0[i*8 +: 8], s1[i*8 +: 8]);
        end
    endtask

    task automatic send_partial(input logic [63:0] s0, input logic [63:0] s1);
        for (int i = 7; i >= 5; i--)
            send_byte(s0[i*8 +: 8], s1[i*8 +: 8]);
    endtask

    task automatic send_data(input logic [15:0] w);
        exp_q.push_back('{cyc + 1, 8'h99, 1'b1, w});
        send_byte(w[7:0], w[15:8]);
    endtask

    // Monitor: every non-idle output cycle must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event: got nothing at cycle %0d, required os_in=%h dv=%b", e.cyc, e.os, e.dv);
            end
            if (bus.os_in !== 8'h99 || bus.transport_layer_data_valid !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got os_in=%h dv=%b at cycle %0d, required idle",
                             bus.os_in, bus.transport_layer_data_valid, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || bus.os_in !== e.os || bus.transport_layer_data_valid !== e.dv ||
                        (e.dv && bus.transport_layer_data_out !== e.data)) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d os_in=%h dv=%b data=%h, required cyc=%0d os_in=%h dv=%b data=%h",
                                 cyc, bus.os_in, bus.transport_layer_data_valid, bus.transport_layer_data_out,
                                 e.cyc, e.os, e.dv, e.data);
                    end else
                        $display("ok   event: cyc=%0d os_in=%h dv=%b data=%h", cyc, bus.os_in,
                                 bus.transport_layer_data_valid, bus.transport_layer_data_out);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ts1_l0, ts1_l1, ts2_l0, g4_good, g4_bad;
        ts1_l0  = 64'h0100_0000_0400_98F2;
        ts1_l1  = 64'h0101_0000_0400_98F2;
        ts2_l0  = 64'h0100_0000_0400_64F2;
        g4_good = 64'h0000_0000_7E04_B0F0;
        g4_bad  = 64'h0000_0000_7E04_B0F1;

        bus.lane_rx_on    = 1'b0;
        bus.lane_rx_valid = 1'b0;
        bus.data_os       = 1'b0;
        bus.d_sel         = 4'd2;
        bus.lane_rx       = '0;
        tick();
        tick();
        chk("reset_os_in", 32'(bus.os_in), 32'h99);
        chk("reset_os_lock", 32'(bus.os_lock), 32'h0);
        chk("reset_data_out", 32'(bus.transport_layer_data_out), 32'h0);
        chk("reset_data_valid", 32'(bus.transport_layer_data_valid), 32'h0);

        // Gen3 TS1: pulse after the second set only, both lanes lock.
        rst = 1'b1;
        bus.lane_rx_on = 1'b1;
        tick();
        tick();
        send_set(ts1_l0, ts1_l1, 8'h99);
        send_set(ts1_l0, ts1_l1, 8'h22);
        send_set(ts1_l0, ts1_l1, 8'h99);
        chk("ts1_lock", 32'(bus.os_lock), 32'h3);

        // Gen4 TS2 repeat gating on lane 0 with a corrupted set in between.
        bus.d_sel = 4'd5;
        tick();
        chk("dsel_change_clears_lock", 32'(bus.os_lock), 32'h0);
        send_set(g4_good, 64'h0, 8'h99);
        send_set(g4_bad, 64'h0, 8'h99);
        send_set(g4_good, 64'h0, 8'h99);
        send_set(g4_good, 64'h0, 8'h95);
        chk("g4ts2_lock", 32'(bus.os_lock), 32'h1);

        // Gen3 TS2 with lane byte 0 on both lanes: only lane 0 locks.
        bus.d_sel = 4'd3;
        tick();
        send_set(ts2_l0, ts2_l0, 8'h99);
        send_set(ts2_l0, ts2_l0, 8'h93);
        send_set(ts2_l0, ts2_l0, 8'h99);
        chk("ts2_lane_field_lock", 32'(bus.os_lock), 32'h1);

        // Data forwarding.
        bus.d_sel   = 4'd8;
        bus.data_os = 1'b1;
        tick();
        send_data(16'hA55A);
        tick();
        chk("data_valid_drops", 32'(bus.transport_layer_data_valid), 32'h0);
        chk("data_held", 32'(bus.transport_layer_data_out), 32'hA55A);
        send_data(16'h3C01);
        send_data(16'h7E80);
        tick();
        chk("data_held2", 32'(bus.transport_layer_data_out), 32'h7E80);
        chk("data_mode_no_lock", 32'(bus.os_lock), 32'h0);

        // Disruption: lane_rx_on drop mid-set, then async reset mid-set.
        bus.data_os = 1'b0;
        bus.d_sel   = 4'd2;
        bus.lane_rx_on = 1'b0;
        tick();
        bus.lane_rx_on = 1'b1;
        tick();
        send_set(ts1_l0, ts1_l1, 8'h99);
        send_partial(ts1_l0, ts1_l1);
        bus.lane_rx_on = 1'b0;
        tick();
        chk("rx_off_os_in", 32'(bus.os_in), 32'h99);
        chk("rx_off_lock", 32'(bus.os_lock), 32'h0);
        chk("rx_off_data_out", 32'(bus.transport_layer_data_out), 32'h0);
        bus.lane_rx_on = 1'b1;
        send_set(ts1_l0, ts1_l1, 8'h99);
        send_set(ts1_l0, ts1_l1, 8'h22);
        chk("relock_after_rx_off", 32'(bus.os_lock), 32'h3);
        send_partial(ts1_l0, ts1_l1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_os_in", 32'(bus.os_in), 32'h99);
        chk("async_reset_lock", 32'(bus.os_lock), 32'h0);
        tick();
        rst = 1'b1;
        send_set(ts1_l0, ts1_l1, 8'h99);
        send_set(ts1_l0, ts1_l1, 8'h22);
        chk("relock_after_reset", 32'(bus.os_lock), 32'h3);

`ifdef LANE_REVERSAL_EN
        // Physical lane 0 carrying lane number 1 is logical lane 1 when reversed.
        lane_reverse = 1'b1;
        tick();
        chk("reverse_clears_lock", 32'(bus.os_lock), 32'h0);
        send_set(ts1_l1, 64'h0, 8'h99);
        send_set(ts1_l1, 64'h0, 8'h29);
        chk("reverse_lock", 32'(bus.os_lock), 32'h2);
`endif

        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
